pipe_prefix_sub: RTL

//  Pipelined WIDTH-bit parallel-prefix (Kogge-Stone) subtractor: diff = a - b - bin.
//  - Counterpart to the pipelined prefix adder; feeds the core ALU subtract/compare path.
//  - Uses a valid/ready handshake on both sides.
//  - Produces borrow-out and the flags ovf/zero/neg.

---
 rtl/pipe_prefix_sub_pkg.sv | 22 ++
 rtl/pipe_prefix_sub_if.sv | 32 +++
 rtl/pipe_prefix_sub_gp_cell.sv | 14 +
 rtl/pipe_prefix_sub.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_prefix_sub_pkg.sv
// Shared types and constants for the pipelined prefix subtractor.
// No logic, no latency, no flow control; imported by every file of the block.
package prefix_pkg;

  localparam int WIDTH    = 32;
  localparam int N_STAGES = 3;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_prefix_sub_if.sv
// Operand/result handshake bundle: valid/ready on both the input and the result side.
// Wires only; slave modport is the subtractor, master modport is its user.
interface pipe_prefix_sub_if
  import prefix_pkg::*;
#(
  parameter int WIDTH = prefix_pkg::WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero, neg
  );

endinterface

// File: rtl/pipe_prefix_sub_gp_cell.sv
// Kogge-Stone black cell combining a high and a low (generate, propagate) pair.
// Purely combinational, no latency, no flow control.
module prefix_gp_cell
  import prefix_pkg::*;
(
  input  gp_t i_hi,
  input  gp_t i_lo,
  output gp_t o_gp
);

  assign o_gp.g = i_hi.g | (i_hi.p & i_lo.g);
  assign o_gp.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/pipe_prefix_sub.sv
// Kogge-Stone subtractor diff = a - b - bin, 3-cycle latency; whole pipe stalls when the output is held.
// PIPE_PREFIX_SUB_SAT_EN selects signed saturation of diff on overflow.
module pipe_prefix_sub
  import prefix_pkg::*;
#(
  parameter int WIDTH = prefix_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_prefix_sub_if.slave   bus
);

  localparam int L  = clog2(WIDTH);
  localparam int L1 = (L + 1) / 2;

  logic             w_adv;
  logic [WIDTH-1:0] w_nb, w_g0, w_p0;
  logic             w_cin;

  logic             r1_vld, r1_cin, r1_amsb, r1_bmsb;
  logic [WIDTH-1:0] r1_g, r1_p;
  logic             r2_vld, r2_cin, r2_amsb, r2_bmsb;
  logic [WIDTH-1:0] r2_g, r2_p, r2_pb;
  logic             r3_vld, r3_bout, r3_ovf, r3_zero, r3_neg;
  logic [WIDTH-1:0] r3_diff;

  logic [WIDTH-1:0] w_g [0:L];
  logic [WIDTH-1:0] w_p [0:L];

  logic [WIDTH-1:0] w_carry, w_raw, w_diff;
  logic             w_bout, w_ovf;

  assign w_adv = !r3_vld || bus.out_ready;
  assign w_nb  = ~bus.b;
  assign w_cin = ~bus.bin;
  assign w_g0  = bus.a & w_nb;
  assign w_p0  = bus.a ^ w_nb;

  assign w_g[0] = r1_g;
  assign w_p[0] = r1_p;

  // Levels up to L1 run off the S1 registers, the rest off the S2 registers.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] s_g, s_p;
    if (k == L1 + 1) begin : g_src_reg
      assign s_g = r2_g;
      assign s_p = r2_p;
    end else begin : g_src_comb
      assign s_g = w_g[k-1];
      assign s_p = w_p[k-1];
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        gp_t w_hi, w_lo, w_o;
        assign w_hi = {s_g[i], s_p[i]};
        assign w_lo = {s_g[i-D], s_p[i-D]};
        prefix_gp_cell u_cell (.i_hi(w_hi), .i_lo(w_lo), .o_gp(w_o));
        assign w_g[k][i] = w_o.g;
        assign w_p[k][i] = w_o.p;
      end else begin : g_pass
        assign w_g[k][i] = s_g[i];
        assign w_p[k][i] = s_p[i];
      end
    end
  end

  // Group generate of bits [i:0] already folds in the carry-in, so it is the carry into bit i+1.
  assign w_carry = {w_g[L][WIDTH-2:0], r2_cin};
  assign w_raw   = r2_pb ^ w_carry;
  assign w_bout  = ~w_g[L][WIDTH-1];
  assign w_ovf   = (r2_amsb != r2_bmsb) && (w_raw[WIDTH-1] != r2_amsb);

`ifdef PIPE_PREFIX_SUB_SAT_EN
  assign w_diff = !w_ovf  ? w_raw :
                  r2_amsb ? {1'b1, {(WIDTH-1){1'b0}}} :
                            {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_diff = w_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vld  <= 1'b0;
      r1_cin  <= 1'b0;
      r1_amsb <= 1'b0;
      r1_bmsb <= 1'b0;
      r1_g    <= '0;
      r1_p    <= '0;
      r2_vld  <= 1'b0;
      r2_cin  <= 1'b0;
      r2_amsb <= 1'b0;
      r2_bmsb <= 1'b0;
      r2_g    <= '0;
      r2_p    <= '0;
      r2_pb   <= '0;
      r3_vld  <= 1'b0;
      r3_diff <= '0;
      r3_bout <= 1'b0;
      r3_ovf  <= 1'b0;
      r3_zero <= 1'b0;
      r3_neg  <= 1'b0;
    end else if (w_adv) begin
      r1_vld  <= bus.in_valid;
      r1_cin  <= w_cin;
      r1_amsb <= bus.a[WIDTH-1];
      r1_bmsb <= bus.b[WIDTH-1];
      r1_g    <= {w_g0[WIDTH-1:1], w_g0[0] | (w_p0[0] & w_cin)};
      r1_p    <= w_p0;
      r2_vld  <= r1_vld;
      r2_cin  <= r1_cin;
      r2_amsb <= r1_amsb;
      r2_bmsb <= r1_bmsb;
      r2_g    <= w_g[L1];
      r2_p    <= w_p[L1];
      r2_pb   <= r1_p;
      r3_vld  <= r2_vld;
      r3_diff <= w_diff;
      r3_bout <= w_bout;
      r3_ovf  <= w_ovf;
      r3_zero <= (w_diff == '0);
      r3_neg  <= w_diff[WIDTH-1];
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r3_vld;
  assign bus.diff      = r3_diff;
  assign bus.bout      = r3_bout;
  assign bus.ovf       = r3_ovf;
  assign bus.zero      = r3_zero;
  assign bus.neg       = r3_neg;

endmodule
